simt_mem_coalescer: RTL and testbench
=====================================

Name: simt_mem_coalescer

Overview:
- Per-thread data-memory fabric between a core's THREADS lane interfaces and CHANNELS shared memory channels. It generalises the fixed one-channel-per-thread memory wiring.
- Arbitrates thread requests round-robin onto any idle channel.
- Coalesces reads: all pending reads to the same address share one channel transaction and receive the same data.
- Sits between the core's LSU ports and the memory controller; all handshakes use the same valid/ready protocol on both sides.

Parameters:
THREADS, 4, number of thread lanes (upstream ports)
CHANNELS, 2, number of downstream memory channels (1..THREADS)
ADDR_BITS, 8, data memory address width
DATA_BITS, 8, data memory word width

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
thr_read_valid  input  [THREADS]  per-thread read request, held until ready
thr_read_address  input  [THREADS][ADDR_BITS]  read address
thr_read_ready  output  [THREADS]  one-cycle read completion pulse
thr_read_data  output  [THREADS][DATA_BITS]  read data, valid with ready
thr_write_valid  input  [THREADS]  per-thread write request, held until ready
thr_write_address  input  [THREADS][ADDR_BITS]  write address
thr_write_data  input  [THREADS][DATA_BITS]  write data
thr_write_ready  output  [THREADS]  one-cycle write completion pulse
mem_read_valid  output  [CHANNELS]  channel read request
mem_read_address  output  [CHANNELS][ADDR_BITS]  channel read address
mem_read_ready  input  [CHANNELS]  channel read done, data valid
mem_read_data  input  [CHANNELS][DATA_BITS]  channel read data
mem_write_valid  output  [CHANNELS]  channel write request
mem_write_address  output  [CHANNELS][ADDR_BITS]  channel write address
mem_write_data  output  [CHANNELS][DATA_BITS]  channel write data
mem_write_ready  input  [CHANNELS]  channel write done

Behaviour:
- Reset (reset=0, async): all outputs 0; channels IDLE; service masks cleared; rr pointer=0. Reset mid-transaction abandons it with no ready pulse.
- Per-channel FSM:
  - IDLE -> READ (or WRITE) on grant.
  - READ/WRITE -> RELAY on the mem_*_ready cycle.
  - RELAY -> IDLE after one cycle.
- Eligible thread: valid high and not in any channel's service mask, including its own RELAY cycle. If a thread has both read and write valid, the read goes first.
- Grant: at most one grant per cycle.
  - Thread chosen: first eligible thread scanning from rr pointer upward with wrap.
  - Channel chosen: lowest-indexed IDLE channel.
  - rr pointer <- granted thread+1 mod THREADS.
  - No IDLE channel: no grant, pointer unchanged.
- Coalescing: on a read grant at address A, the service mask = all eligible threads with read valid and address A. Threads arriving later with A are not merged; they take a later grant.
- Writes are never coalesced. Same-address writes are serialised in rr order.
- Latency:
  - Grant in cycle N -> mem_*_valid/address/data registered high in N+1, held stable until mem_*_ready.
  - mem ready in cycle M -> valid low in M+1.
  - Read data is captured in M; in M+1 (RELAY) every masked thread gets thr_read_ready=1 with the captured data. Writes pulse thr_write_ready instead.
  - Channel is IDLE in M+2 and re-grantable in that cycle.
- Minimum thread-visible latency: 3 cycles (grant, mem cycle, relay) with zero-wait memory.
- thr_*_ready is a single-cycle pulse. The upstream drops valid the cycle after the pulse. thr_read_data holds its last value when ready is low.
- Simultaneous ready on several channels relays all of them in the same cycle; the masks are disjoint by construction.
- CHANNELS=THREADS with no address matches reproduces the per-thread wiring, plus arbitration latency.

Test Plan:
- Single read: T0 reads 0x10, mem replies 0xAB after 2 wait cycles -> ch0 read_valid 1 cycle after request, thr_read_ready[0] pulse with 0xAB the cycle after mem ready.
- Coalesce: T0..T3 read 0x20 in the same cycle -> one ch0 transaction; all four thr_read_ready pulse together with 0x5C; ch1 unused.
- Contention: CHANNELS=2, T0..T3 read distinct addresses 0x00..0x03 -> grants in order T0->ch0, T1->ch1; T2 and T3 wait for a free channel; each thread gets its own data.
- Round-robin fairness: T1 and T3 issue back-to-back writes, one channel, rr pointer at 2 -> order T3, T1, T3, T1; same-address writes land in that order.
- Mixed read/write on one thread: T2 has both valid -> read served first, write afterwards on a separate grant.
- Reset mid-op: assert reset while ch0 is in READ -> all outputs 0 immediately; after release, a fresh request completes normally and the abandoned thread gets no pulse.

Source files
------------

// File: rtl/simt_mem_coalescer.sv
// simt_mem_coalescer: connects THREADS per-lane LSU ports to CHANNELS shared
// memory channels. One request is granted per cycle (round-robin over threads,
// lowest idle channel). Reads to the same address that are pending together
// share one channel transaction.
module simt_mem_coalescer #(
    parameter int THREADS   = 4,
    parameter int CHANNELS  = 2,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [THREADS-1:0]                  thr_read_valid,
    input  logic [THREADS-1:0][ADDR_BITS-1:0]   thr_read_address,
    output logic [THREADS-1:0]                  thr_read_ready,
    output logic [THREADS-1:0][DATA_BITS-1:0]   thr_read_data,
    input  logic [THREADS-1:0]                  thr_write_valid,
    input  logic [THREADS-1:0][ADDR_BITS-1:0]   thr_write_address,
    input  logic [THREADS-1:0][DATA_BITS-1:0]   thr_write_data,
    output logic [THREADS-1:0]                  thr_write_ready,
    output logic [CHANNELS-1:0]                 mem_read_valid,
    output logic [CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [CHANNELS-1:0]                 mem_read_ready,
    input  logic [CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic [CHANNELS-1:0]                 mem_write_valid,
    output logic [CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    output logic [CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    input  logic [CHANNELS-1:0]                 mem_write_ready
);

    localparam int PTR_BITS = (THREADS > 1) ? $clog2(THREADS) : 1;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_READ,
        CH_WRITE,
        CH_RELAY
    } ch_state_t;

    ch_state_t              ch_state [CHANNELS];
    logic [THREADS-1:0]     ch_mask  [CHANNELS];
    logic [PTR_BITS-1:0]    rr_ptr;

    logic [THREADS-1:0]     busy_mask;
    logic [THREADS-1:0]     eligible;
    logic [CHANNELS-1:0]    grant_chan_oh;
    logic                   thread_found;
    logic [PTR_BITS-1:0]    grant_thread;
    int                     scan_idx;
    logic                   grant_valid;
    logic                   grant_is_read;
    logic [ADDR_BITS-1:0]   grant_addr;
    logic [DATA_BITS-1:0]   grant_data;
    logic [THREADS-1:0]     grant_mask;
    logic [PTR_BITS-1:0]    rr_next;

    // A thread is eligible when it has a request and no channel (including one in RELAY) is serving it
    always_comb begin
        busy_mask = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            busy_mask = busy_mask | ch_mask[c];
        end
        eligible = (thr_read_valid | thr_write_valid) & ~busy_mask;
    end

    // Pick the lowest-indexed idle channel as a one-hot vector
    always_comb begin
        grant_chan_oh = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant_chan_oh == '0 && ch_state[c] == CH_IDLE) begin
                grant_chan_oh[c] = 1'b1;
            end
        end
    end

    // Pick the first eligible thread scanning upward from the round-robin pointer
    always_comb begin
        thread_found = 1'b0;
        grant_thread = '0;
        scan_idx     = 0;
        for (int i = 0; i < THREADS; i++) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= THREADS) begin
                scan_idx = scan_idx - THREADS;
            end
            if (!thread_found && eligible[scan_idx]) begin
                thread_found = 1'b1;
                grant_thread = scan_idx[PTR_BITS-1:0];
            end
        end
    end

    // Build the grant: reads win over writes and absorb every eligible same-address reader
    always_comb begin
        grant_valid   = thread_found && (grant_chan_oh != '0);
        grant_is_read = thr_read_valid[grant_thread];
        grant_addr    = grant_is_read ? thr_read_address[grant_thread]
                                      : thr_write_address[grant_thread];
        grant_data    = thr_write_data[grant_thread];
        grant_mask    = '0;
        if (grant_is_read) begin
            for (int t = 0; t < THREADS; t++) begin
                grant_mask[t] = eligible[t] && thr_read_valid[t] &&
                                (thr_read_address[t] == grant_addr);
            end
        end else begin
            grant_mask[grant_thread] = 1'b1;
        end
        rr_next = (grant_thread == PTR_BITS'(THREADS - 1)) ? '0
                                                           : grant_thread + PTR_BITS'(1);
    end

    // Channel FSMs, round-robin pointer and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr            <= '0;
            thr_read_ready    <= '0;
            thr_read_data     <= '0;
            thr_write_ready   <= '0;
            mem_read_valid    <= '0;
            mem_read_address  <= '0;
            mem_write_valid   <= '0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                ch_state[c] <= CH_IDLE;
                ch_mask[c]  <= '0;
            end
        end else begin
            thr_read_ready  <= '0;
            thr_write_ready <= '0;
            if (grant_valid) begin
                rr_ptr <= rr_next;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                case (ch_state[c])
                    CH_IDLE: begin
                        if (grant_valid && grant_chan_oh[c]) begin
                            ch_mask[c] <= grant_mask;
                            if (grant_is_read) begin
                                ch_state[c]         <= CH_READ;
                                mem_read_valid[c]   <= 1'b1;
                                mem_read_address[c] <= grant_addr;
                            end else begin
                                ch_state[c]          <= CH_WRITE;
                                mem_write_valid[c]   <= 1'b1;
                                mem_write_address[c] <= grant_addr;
                                mem_write_data[c]    <= grant_data;
                            end
                        end
                    end
                    CH_READ: begin
                        if (mem_read_ready[c]) begin
                            ch_state[c]       <= CH_RELAY;
                            mem_read_valid[c] <= 1'b0;
                            for (int t = 0; t < THREADS; t++) begin
                                if (ch_mask[c][t]) begin
                                    thr_read_ready[t] <= 1'b1;
                                    thr_read_data[t]  <= mem_read_data[c];
                                end
                            end
                        end
                    end
                    CH_WRITE: begin
                        if (mem_write_ready[c]) begin
                            ch_state[c]        <= CH_RELAY;
                            mem_write_valid[c] <= 1'b0;
                            for (int t = 0; t < THREADS; t++) begin
                                if (ch_mask[c][t]) begin
                                    thr_write_ready[t] <= 1'b1;
                                end
                            end
                        end
                    end
                    CH_RELAY: begin
                        ch_state[c] <= CH_IDLE;
                        ch_mask[c]  <= '0;
                    end
                    default: begin
                        ch_state[c] <= CH_IDLE;
                        ch_mask[c]  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_simt_mem_coalescer.sv
// tb_simt_mem_coalescer: directed checks of the memory coalescer. u_dut has
// four threads and two channels; u_single has one channel for the
// round-robin write-ordering scenario. Each channel is backed by a small
// memory model with a programmable number of wait cycles.
module tb_simt_mem_coalescer;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic [3:0]       thr_read_valid;
    logic [3:0][7:0]  thr_read_address;
    logic [3:0]       thr_read_ready;
    logic [3:0][7:0]  thr_read_data;
    logic [3:0]       thr_write_valid;
    logic [3:0][7:0]  thr_write_address;
    logic [3:0][7:0]  thr_write_data;
    logic [3:0]       thr_write_ready;
    logic [1:0]       mem_read_valid;
    logic [1:0][7:0]  mem_read_address;
    logic [1:0]       mem_read_ready;
    logic [1:0][7:0]  mem_read_data;
    logic [1:0]       mem_write_valid;
    logic [1:0][7:0]  mem_write_address;
    logic [1:0][7:0]  mem_write_data;
    logic [1:0]       mem_write_ready;

    logic [3:0]       s_read_valid;
    logic [3:0][7:0]  s_read_address;
    logic [3:0]       s_read_ready;
    logic [3:0][7:0]  s_read_data;
    logic [3:0]       s_write_valid;
    logic [3:0][7:0]  s_write_address;
    logic [3:0][7:0]  s_write_data;
    logic [3:0]       s_write_ready;
    logic [0:0]       s_mem_read_valid;
    logic [0:0][7:0]  s_mem_read_address;
    logic [0:0]       s_mem_read_ready;
    logic [0:0][7:0]  s_mem_read_data;
    logic [0:0]       s_mem_write_valid;
    logic [0:0][7:0]  s_mem_write_address;
    logic [0:0][7:0]  s_mem_write_data;
    logic [0:0]       s_mem_write_ready;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] s_log [$];
    int         mem_wait;
    int         tests_run = 0;
    int         tests_failed = 0;
    int         cyc = 0;

    simt_mem_coalescer #(.THREADS(4), .CHANNELS(2), .ADDR_BITS(8), .DATA_BITS(8)) u_dut (
        .clk(clk), .reset(reset),
        .thr_read_valid(thr_read_valid), .thr_read_address(thr_read_address),
        .thr_read_ready(thr_read_ready), .thr_read_data(thr_read_data),
        .thr_write_valid(thr_write_valid), .thr_write_address(thr_write_address),
        .thr_write_data(thr_write_data), .thr_write_ready(thr_write_ready),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
    );

    simt_mem_coalescer #(.THREADS(4), .CHANNELS(1), .ADDR_BITS(8), .DATA_BITS(8)) u_single (
        .clk(clk), .reset(reset),
        .thr_read_valid(s_read_valid), .thr_read_address(s_read_address),
        .thr_read_ready(s_read_ready), .thr_read_data(s_read_data),
        .thr_write_valid(s_write_valid), .thr_write_address(s_write_address),
        .thr_write_data(s_write_data), .thr_write_ready(s_write_ready),
        .mem_read_valid(s_mem_read_valid), .mem_read_address(s_mem_read_address),
        .mem_read_ready(s_mem_read_ready), .mem_read_data(s_mem_read_data),
        .mem_write_valid(s_mem_write_valid), .mem_write_address(s_mem_write_address),
        .mem_write_data(s_mem_write_data), .mem_write_ready(s_mem_write_ready)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Memory model for u_dut: answers each channel after mem_wait cycles of valid
    initial begin
        int rcnt [2];
        int wcnt [2];
        for (int i = 0; i < 256; i++) mem0[i] = 8'h00;
        mem0[8'h10] = 8'hAB;
        mem0[8'h20] = 8'h5C;
        mem0[8'h00] = 8'hC0;
        mem0[8'h01] = 8'hC1;
        mem0[8'h02] = 8'hC2;
        mem0[8'h03] = 8'hC3;
        mem0[8'h50] = 8'h77;
        mem0[8'h61] = 8'h42;
        rcnt[0] = 0; rcnt[1] = 0; wcnt[0] = 0; wcnt[1] = 0;
        mem_read_ready  = '0;
        mem_read_data   = '0;
        mem_write_ready = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (mem_read_valid[c] && !mem_read_ready[c]) begin
                    if (rcnt[c] >= mem_wait) begin
                        mem_read_ready[c] = 1'b1;
                        mem_read_data[c]  = mem0[mem_read_address[c]];
                        rcnt[c] = 0;
                    end else begin
                        rcnt[c]++;
                    end
                end else begin
                    mem_read_ready[c] = 1'b0;
                    rcnt[c] = 0;
                end
                if (mem_write_valid[c] && !mem_write_ready[c]) begin
                    if (wcnt[c] >= mem_wait) begin
                        mem_write_ready[c] = 1'b1;
                        mem0[mem_write_address[c]] = mem_write_data[c];
                        wcnt[c] = 0;
                    end else begin
                        wcnt[c]++;
                    end
                end else begin
                    mem_write_ready[c] = 1'b0;
                    wcnt[c] = 0;
                end
            end
        end
    end

    // Zero-wait memory model for u_single; logs every write's data in arrival order
    initial begin
        for (int i = 0; i < 256; i++) mem1[i] = 8'h00;
        s_mem_read_ready  = '0;
        s_mem_read_data   = '0;
        s_mem_write_ready = '0;
        forever begin
            @(negedge clk);
            if (s_mem_read_valid[0] && !s_mem_read_ready[0]) begin
                s_mem_read_ready[0] = 1'b1;
                s_mem_read_data[0]  = mem1[s_mem_read_address[0]];
            end else begin
                s_mem_read_ready[0] = 1'b0;
            end
            if (s_mem_write_valid[0] && !s_mem_write_ready[0]) begin
                s_mem_write_ready[0] = 1'b1;
                mem1[s_mem_write_address[0]] = s_mem_write_data[0];
                s_log.push_back(s_mem_write_data[0]);
            end else begin
                s_mem_write_ready[0] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int t, input logic rd, input logic wr,
                                 input logic [7:0] addr, input logic [7:0] data);
        thr_read_valid[t]    = rd;
        thr_read_address[t]  = addr;
        thr_write_valid[t]   = wr;
        thr_write_address[t] = addr;
        thr_write_data[t]    = data;
    endtask

    task automatic doReset();
        reset = 1'b0;
        thr_read_valid = '0; thr_read_address = '0;
        thr_write_valid = '0; thr_write_address = '0; thr_write_data = '0;
        s_read_valid = '0; s_read_address = '0;
        s_write_valid = '0; s_write_address = '0; s_write_data = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Directed scenarios
    initial begin
        logic [3:0] done;
        int rem [4];
        int order [$];
        int rd_cycle, wr_cycle, ghost;
        logic rd_seen, wr_seen, seen;

        mem_wait = 0;
        doReset();
        reset = 1'b0;
        tick();
        checkOutput("rst_mem_read_valid", 32'(mem_read_valid), 32'h0);
        checkOutput("rst_mem_write_valid", 32'(mem_write_valid), 32'h0);
        checkOutput("rst_thr_read_ready", 32'(thr_read_ready), 32'h0);
        checkOutput("rst_thr_read_data", 32'(thr_read_data), 32'h0);
        reset = 1'b1;

        // Single read with two wait cycles
        mem_wait = 2;
        applyStimulus(0, 1'b1, 1'b0, 8'h10, 8'h00);
        tick();
        checkOutput("t1_rvalid", 32'(mem_read_valid), 32'h1);
        checkOutput("t1_raddr", 32'(mem_read_address[0]), 32'h10);
        tick();
        tick();
        checkOutput("t1_wait_ready", 32'(thr_read_ready), 32'h0);
        checkOutput("t1_wait_rvalid", 32'(mem_read_valid), 32'h1);
        tick();
        checkOutput("t1_pulse", 32'(thr_read_ready), 32'h1);
        checkOutput("t1_data", 32'(thr_read_data[0]), 32'hAB);
        checkOutput("t1_rvalid_low", 32'(mem_read_valid), 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 8'h10, 8'h00);
        tick();
        checkOutput("t1_pulse_end", 32'(thr_read_ready), 32'h0);
        checkOutput("t1_data_hold", 32'(thr_read_data[0]), 32'hAB);

        // Four threads coalesced onto one transaction
        doReset();
        mem_wait = 0;
        for (int t = 0; t < 4; t++) applyStimulus(t, 1'b1, 1'b0, 8'h20, 8'h00);
        tick();
        checkOutput("t2_rvalid", 32'(mem_read_valid), 32'h1);
        checkOutput("t2_raddr", 32'(mem_read_address[0]), 32'h20);
        tick();
        checkOutput("t2_pulse", 32'(thr_read_ready), 32'hF);
        for (int t = 0; t < 4; t++) checkOutput("t2_data", 32'(thr_read_data[t]), 32'h5C);
        checkOutput("t2_ch1_unused", 32'(mem_read_valid), 32'h0);
        for (int t = 0; t < 4; t++) applyStimulus(t, 1'b0, 1'b0, 8'h20, 8'h00);
        tick();
        checkOutput("t2_pulse_end", 32'(thr_read_ready), 32'h0);

        // Four distinct reads contending for two channels
        doReset();
        mem_wait = 1;
        for (int t = 0; t < 4; t++) applyStimulus(t, 1'b1, 1'b0, 8'(t), 8'h00);
        tick();
        checkOutput("t3_first_grant", 32'(mem_read_valid), 32'h1);
        checkOutput("t3_ch0_addr", 32'(mem_read_address[0]), 32'h00);
        tick();
        checkOutput("t3_second_grant", 32'(mem_read_valid), 32'h3);
        checkOutput("t3_ch1_addr", 32'(mem_read_address[1]), 32'h01);
        done = '0;
        for (int n = 0; n < 40 && done != 4'hF; n++) begin
            tick();
            for (int t = 0; t < 4; t++) begin
                if (thr_read_ready[t]) begin
                    checkOutput("t3_data", 32'(thr_read_data[t]), 32'hC0 + 32'(t));
                    done[t] = 1'b1;
                    thr_read_valid[t] = 1'b0;
                end
            end
        end
        checkOutput("t3_all_done", 32'(done), 32'hF);

        // Round-robin write ordering on the single-channel instance
        doReset();
        s_write_valid[1] = 1'b1; s_write_address[1] = 8'h41; s_write_data[1] = 8'h01;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            if (s_write_ready[1]) begin
                seen = 1'b1;
                s_write_valid[1] = 1'b0;
            end
        end
        checkOutput("t4_setup", 32'(seen), 32'h1);
        tick();
        s_log.delete();
        rem[1] = 2; rem[3] = 2;
        s_write_valid[1] = 1'b1; s_write_address[1] = 8'h40; s_write_data[1] = 8'h10;
        s_write_valid[3] = 1'b1; s_write_address[3] = 8'h40; s_write_data[3] = 8'h30;
        for (int n = 0; n < 40 && (rem[1] + rem[3]) > 0; n++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                int t;
                t = (k == 0) ? 1 : 3;
                if (s_write_ready[t]) begin
                    order.push_back(t);
                    s_write_valid[t] = 1'b0;
                    rem[t]--;
                end else if (!s_write_valid[t] && rem[t] > 0) begin
                    s_write_valid[t] = 1'b1;
                    s_write_data[t]  = ((t == 1) ? 8'h10 : 8'h30) + 8'(2 - rem[t]);
                end
            end
        end
        checkOutput("t4_count", 32'(order.size()), 32'd4);
        if (order.size() == 4) begin
            checkOutput("t4_order0", 32'(order[0]), 32'd3);
            checkOutput("t4_order1", 32'(order[1]), 32'd1);
            checkOutput("t4_order2", 32'(order[2]), 32'd3);
            checkOutput("t4_order3", 32'(order[3]), 32'd1);
        end
        checkOutput("t4_log_count", 32'(s_log.size()), 32'd4);
        if (s_log.size() == 4) begin
            checkOutput("t4_log0", 32'(s_log[0]), 32'h30);
            checkOutput("t4_log1", 32'(s_log[1]), 32'h10);
            checkOutput("t4_log2", 32'(s_log[2]), 32'h31);
            checkOutput("t4_log3", 32'(s_log[3]), 32'h11);
        end
        checkOutput("t4_final_mem", 32'(mem1[8'h40]), 32'h11);

        // Read and write pending together on one thread
        doReset();
        mem_wait = 0;
        applyStimulus(2, 1'b1, 1'b1, 8'h50, 8'h99);
        tick();
        checkOutput("t5_read_first", 32'(mem_read_valid), 32'h1);
        checkOutput("t5_raddr", 32'(mem_read_address[0]), 32'h50);
        checkOutput("t5_no_write_yet", 32'(mem_write_valid), 32'h0);
        rd_seen = 1'b0; wr_seen = 1'b0; rd_cycle = 0; wr_cycle = 0;
        for (int n = 0; n < 20 && !(rd_seen && wr_seen); n++) begin
            tick();
            if (thr_read_ready[2]) begin
                checkOutput("t5_rdata", 32'(thr_read_data[2]), 32'h77);
                rd_seen = 1'b1;
                rd_cycle = cyc;
                thr_read_valid[2] = 1'b0;
            end
            if (thr_write_ready[2]) begin
                wr_seen = 1'b1;
                wr_cycle = cyc;
                thr_write_valid[2] = 1'b0;
            end
        end
        checkOutput("t5_read_seen", 32'(rd_seen), 32'h1);
        checkOutput("t5_write_seen", 32'(wr_seen), 32'h1);
        checkOutput("t5_write_after_read", 32'(wr_cycle > rd_cycle), 32'h1);
        checkOutput("t5_mem", 32'(mem0[8'h50]), 32'h99);

        // Reset while channel 0 is mid-read
        doReset();
        mem_wait = 5;
        applyStimulus(1, 1'b1, 1'b0, 8'h60, 8'h00);
        tick();
        checkOutput("t6_rvalid", 32'(mem_read_valid), 32'h1);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("t6_rst_rvalid", 32'(mem_read_valid), 32'h0);
        checkOutput("t6_rst_raddr", 32'(mem_read_address), 32'h0);
        checkOutput("t6_rst_ready", 32'(thr_read_ready), 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 8'h60, 8'h00);
        tick();
        reset = 1'b1;
        mem_wait = 0;
        applyStimulus(0, 1'b1, 1'b0, 8'h61, 8'h00);
        seen = 1'b0; ghost = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (thr_read_ready[1]) ghost++;
            if (thr_read_ready[0]) begin
                checkOutput("t6_fresh_data", 32'(thr_read_data[0]), 32'h42);
                seen = 1'b1;
                thr_read_valid[0] = 1'b0;
            end
        end
        checkOutput("t6_fresh_done", 32'(seen), 32'h1);
        checkOutput("t6_no_ghost", 32'(ghost), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
